// File: rtl/rpn_engine_if.sv
// Command handshake bundle for rpn_engine: valid/ready plus opcode and operand.
// The master drives commands; the slave (the engine) answers with ready.
interface rpn_engine_if #(
    parameter int WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_val;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_val,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_val,
        output cmd_ready
    );
endinterface

// File: rtl/rpn_engine.sv
// rpn_engine: register-file RPN stack with integrated ALU and a three-state
// command sequencer (IDLE/CALC/WB). Single-cycle commands finish on the accept
// edge; binary ops and SWAP take two further edges.
// Optional feature macro: RPN_MUL_EN enables the opcode 11 multiplier; when it
// is undefined no multiplier exists and opcode 11 reports an illegal op.
module rpn_engine #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    rpn_engine_if.slave      cmd,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] next,
    output logic [CW-1:0]    depth,
    output logic [1:0]       err_code,
    output logic             busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]    FULL = CW'(DEPTH);
    localparam logic [CW-1:0]    ONE  = CW'(1);
    localparam logic [CW-1:0]    TWO  = CW'(2);
    localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

`ifdef RPN_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    localparam logic [3:0] OP_PUSH = 4'd0;
    localparam logic [3:0] OP_POP  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_SWAP = 4'd12;
    localparam logic [3:0] OP_DUP  = 4'd13;
    localparam logic [3:0] OP_CLR  = 4'd14;
    localparam logic [3:0] OP_ILL  = 4'd15;

    typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

    state_t           state;
    logic [WIDTH-1:0] stack [DEPTH];
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_m1;
    logic [AW-1:0]    idx_top;
    logic [AW-1:0]    idx_next;
    logic [AW-1:0]    idx_push;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] opn;
    logic [WIDTH-1:0] opt;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] alu_res;
    logic             is_two_operand;
    logic             op_illegal;

    assign cnt_m1   = cnt - ONE;
    assign idx_top  = cnt_m1[AW-1:0];
    assign idx_next = idx_top - AW'(1);
    assign idx_push = cnt[AW-1:0];

    assign top   = (cnt != '0) ? stack[idx_top]  : '0;
    assign next  = (cnt >= TWO) ? stack[idx_next] : '0;
    assign depth = cnt;

    // Classify the incoming opcode: two-operand commands go through CALC/WB
    always_comb begin
        is_two_operand = ((cmd.cmd_op >= OP_ADD) && (cmd.cmd_op <= OP_MUL))
                         || (cmd.cmd_op == OP_SWAP);
        op_illegal     = (cmd.cmd_op == OP_ILL) || ((cmd.cmd_op == OP_MUL) && !MUL_EN);
    end

    // ALU on the captured operands; N is the left operand, T the right
    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = opn + opt;
            OP_SUB:  alu_res = opn - opt;
            OP_SHL:  alu_res = (opt >= WLIM) ? '0 : (opn << opt);
            OP_SHR:  alu_res = (opt >= WLIM) ? '0 : (opn >> opt);
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (opn < opt)};
            OP_AND:  alu_res = opn & opt;
            OP_OR:   alu_res = opn | opt;
            OP_NOR:  alu_res = ~(opn | opt);
            OP_XOR:  alu_res = opn ^ opt;
`ifdef RPN_MUL_EN
            OP_MUL:  alu_res = opn * opt;
`endif
            default: alu_res = '0;
        endcase
    end

    // Command sequencer, stack register file and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            err_code      <= 2'd0;
            cmd.cmd_ready <= 1'b1;
            busy          <= 1'b0;
            op_q          <= OP_PUSH;
            opn           <= '0;
            opt           <= '0;
            res_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid && cmd.cmd_ready) begin
                        err_code <= 2'd0;
                        if (op_illegal) begin
                            err_code <= 2'd3;
                        end else if (is_two_operand) begin
                            if (cnt < TWO) begin
                                err_code <= 2'd1;
                            end else begin
                                op_q          <= cmd.cmd_op;
                                opn           <= next;
                                opt           <= top;
                                state         <= CALC;
                                cmd.cmd_ready <= 1'b0;
                                busy          <= 1'b1;
                            end
                        end else begin
                            case (cmd.cmd_op)
                                OP_PUSH: begin
                                    if (cnt == FULL) begin
                                        err_code <= 2'd2;
                                    end else begin
                                        stack[idx_push] <= cmd.cmd_val;
                                        cnt             <= cnt + ONE;
                                    end
                                end
                                OP_POP: begin
                                    if (cnt == '0) err_code <= 2'd1;
                                    else           cnt      <= cnt_m1;
                                end
                                OP_DUP: begin
                                    if (cnt == '0) begin
                                        err_code <= 2'd1;
                                    end else if (cnt == FULL) begin
                                        err_code <= 2'd2;
                                    end else begin
                                        stack[idx_push] <= top;
                                        cnt             <= cnt + ONE;
                                    end
                                end
                                OP_CLR:  cnt <= '0;
                                default: ;
                            endcase
                        end
                    end
                end
                CALC: begin
                    res_q <= alu_res;
                    state <= WB;
                end
                WB: begin
                    if (op_q == OP_SWAP) begin
                        stack[idx_top]  <= opn;
                        stack[idx_next] <= opt;
                    end else begin
                        stack[idx_next] <= res_q;
                        cnt             <= cnt_m1;
                    end
                    state         <= IDLE;
                    cmd.cmd_ready <= 1'b1;
                    busy          <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    cmd.cmd_ready <= 1'b1;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_engine.sv
// Self-checking bench for rpn_engine: directed scenarios with literal
// expectations, then randomized commands checked every cycle against a
// queue-based model of the stack.
module tb_rpn_engine;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

`ifdef RPN_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    localparam logic [3:0] OP_PUSH = 4'd0;
    localparam logic [3:0] OP_POP  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_SWAP = 4'd12;
    localparam logic [3:0] OP_CLR  = 4'd14;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] next;
    logic [CW-1:0]    depth;
    logic [1:0]       err_code;
    logic             busy;

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    rpn_engine_if #(.WIDTH(WIDTH)) bus ();

    rpn_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (bus),
        .top      (top),
        .next     (next),
        .depth    (depth),
        .err_code (err_code),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference model state: stack as a queue, top at the back
    int unsigned mq[$];
    int          mErr   = 0;
    bit          mReady = 1'b1;
    int          mPend  = 0;
    int          mPendOp = 0;
    int unsigned mPendRes = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int unsigned modelAlu(input int op, input int unsigned n, input int unsigned t);
        longint unsigned a, b, r, mask;
        a = n;
        b = t;
        mask = (64'd1 << WIDTH) - 1;
        case (op)
            2:  r = a + b;
            3:  r = a - b;
            4:  r = (b >= WIDTH) ? 0 : (a << b);
            5:  r = (b >= WIDTH) ? 0 : (a >> b);
            6:  r = (a < b) ? 1 : 0;
            7:  r = a & b;
            8:  r = a | b;
            9:  r = ~(a | b);
            10: r = a ^ b;
            11: r = a * b;
            default: r = 0;
        endcase
        return int'(r & mask);
    endfunction

    // Model update on each rising edge: accept, pending completion or reset
    always @(posedge clk) begin
        int n;
        int op;
        int unsigned tmp;
        n = mq.size();
        if (!rst) begin
            mq.delete();
            mErr   = 0;
            mReady = 1'b1;
            mPend  = 0;
        end else if (mPend > 0) begin
            mPend--;
            if (mPend == 0) begin
                if (mPendOp == 12) begin
                    tmp       = mq[n-1];
                    mq[n-1]   = mq[n-2];
                    mq[n-2]   = tmp;
                end else begin
                    void'(mq.pop_back());
                    void'(mq.pop_back());
                    mq.push_back(mPendRes);
                end
                mReady = 1'b1;
            end
        end else if (bus.cmd_valid && mReady) begin
            op = int'(bus.cmd_op);
            if (op == 0) begin
                if (n == DEPTH) mErr = 2;
                else begin mErr = 0; mq.push_back(int'(bus.cmd_val)); end
            end else if (op == 1) begin
                if (n == 0) mErr = 1;
                else begin mErr = 0; void'(mq.pop_back()); end
            end else if (op >= 2 && op <= 12) begin
                if (op == 11 && !MUL_EN) mErr = 3;
                else if (n < 2) mErr = 1;
                else begin
                    mErr     = 0;
                    mPend    = 2;
                    mReady   = 1'b0;
                    mPendOp  = op;
                    mPendRes = (op == 12) ? 0 : modelAlu(op, mq[n-2], mq[n-1]);
                end
            end else if (op == 13) begin
                if (n == 0) mErr = 1;
                else if (n == DEPTH) mErr = 2;
                else begin mErr = 0; mq.push_back(mq[n-1]); end
            end else if (op == 14) begin
                mErr = 0;
                mq.delete();
            end else begin
                mErr = 3;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        int n;
        if (checkEn) begin
            n = mq.size();
            checkOutput("top",      32'(top),      (n > 0) ? mq[n-1] : 0);
            checkOutput("next",     32'(next),     (n > 1) ? mq[n-2] : 0);
            checkOutput("depth",    32'(depth),    n);
            checkOutput("err_code", 32'(err_code), mErr);
            checkOutput("cmd_ready", 32'(bus.cmd_ready), 32'(mReady));
            checkOutput("busy",     32'(busy),     32'(!mReady));
        end
    end

    task automatic applyStimulus(input logic [3:0] op, input logic [WIDTH-1:0] val);
        int w;
        w = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_val   = val;
        while (bus.cmd_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            total++;
            bad++;
            $display("[TB] FAIL acceptTimeout: got no cmd_ready after %0d cycles, want ready within 20", w);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'($urandom);
        bus.cmd_val   = WIDTH'($urandom);
    endtask

    task automatic waitIdle();
        int w;
        w = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            total++;
            bad++;
            $display("[TB] FAIL idleTimeout: got busy after %0d cycles, want idle within 20", w);
        end
    endtask

    initial begin
        int lowCnt;
        int r;
        logic [3:0] op;
        logic [WIDTH-1:0] val;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'd0;
        bus.cmd_val   = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        checkEn = 1'b1;
        checkOutput("reset_depth", 32'(depth), 0);
        checkOutput("reset_top",   32'(top),   0);
        checkOutput("reset_err",   32'(err_code), 0);
        checkOutput("reset_ready", 32'(bus.cmd_ready), 1);

        // 7 - 3 with the busy window measured
        applyStimulus(OP_PUSH, 16'd7);
        applyStimulus(OP_PUSH, 16'd3);
        applyStimulus(OP_SUB, 16'd0);
        lowCnt = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && lowCnt < 10) begin
            lowCnt++;
            @(negedge clk);
        end
        checkOutput("sub_ready_low_cycles", lowCnt, 2);
        checkOutput("sub_top",   32'(top),   4);
        checkOutput("sub_depth", 32'(depth), 1);
        checkOutput("sub_err",   32'(err_code), 0);

        // Shift left, in range and by the full width
        applyStimulus(OP_CLR, 16'd0);
        applyStimulus(OP_PUSH, 16'h00F0);
        applyStimulus(OP_PUSH, 16'd4);
        applyStimulus(OP_SHL, 16'd0);
        waitIdle();
        checkOutput("shl4_top", 32'(top), 32'h0F00);
        applyStimulus(OP_PUSH, 16'd16);
        applyStimulus(OP_SHL, 16'd0);
        waitIdle();
        checkOutput("shl16_top", 32'(top), 0);

        // Fill to capacity back-to-back, then overflow
        applyStimulus(OP_CLR, 16'd0);
        for (int i = 1; i <= 16; i++) applyStimulus(OP_PUSH, WIDTH'(i));
        checkOutput("fill_depth", 32'(depth), 16);
        applyStimulus(OP_PUSH, 16'd17);
        checkOutput("ovf_err",   32'(err_code), 2);
        checkOutput("ovf_depth", 32'(depth), 16);
        checkOutput("ovf_top",   32'(top), 16);

        // Underflow from empty, cleared by the next good command
        applyStimulus(OP_CLR, 16'd0);
        applyStimulus(OP_ADD, 16'd0);
        checkOutput("unf_err",   32'(err_code), 1);
        checkOutput("unf_depth", 32'(depth), 0);
        checkOutput("unf_top",   32'(top), 0);
        applyStimulus(OP_PUSH, 16'd5);
        checkOutput("unf_clear_err", 32'(err_code), 0);
        checkOutput("unf_clear_top", 32'(top), 5);

        // SWAP then SLTU
        applyStimulus(OP_CLR, 16'd0);
        applyStimulus(OP_PUSH, 16'hA);
        applyStimulus(OP_PUSH, 16'hB);
        applyStimulus(OP_SWAP, 16'd0);
        waitIdle();
        checkOutput("swap_top",  32'(top),  32'hA);
        checkOutput("swap_next", 32'(next), 32'hB);
        applyStimulus(OP_SLTU, 16'd0);
        waitIdle();
        checkOutput("sltu_top",   32'(top), 0);
        checkOutput("sltu_depth", 32'(depth), 1);

        // Reset while ADD(2,3) is in CALC aborts the write-back
        applyStimulus(OP_CLR, 16'd0);
        applyStimulus(OP_PUSH, 16'd2);
        applyStimulus(OP_PUSH, 16'd3);
        applyStimulus(OP_ADD, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checkOutput("rstcalc_depth", 32'(depth), 0);
        checkOutput("rstcalc_top",   32'(top), 0);
        repeat (3) @(negedge clk);
        checkOutput("rstcalc_later_depth", 32'(depth), 0);

        // Multiply, or illegal-op reporting when compiled out
        applyStimulus(OP_PUSH, 16'h0100);
        applyStimulus(OP_PUSH, 16'h0100);
        applyStimulus(OP_MUL, 16'd0);
        waitIdle();
`ifdef RPN_MUL_EN
        checkOutput("mul_top",   32'(top), 0);
        checkOutput("mul_depth", 32'(depth), 1);
        checkOutput("mul_err",   32'(err_code), 0);
`else
        checkOutput("mul_err",   32'(err_code), 3);
        checkOutput("mul_depth", 32'(depth), 2);
        checkOutput("mul_top",   32'(top), 32'h0100);
`endif

        // Randomized command stream checked by the model every cycle
        applyStimulus(OP_CLR, 16'd0);
        repeat (600) begin
            r = $urandom_range(0, 99);
            if (r < 35) op = OP_PUSH;
            else op = 4'($urandom_range(1, 15));
            if (op == OP_CLR && $urandom_range(0, 3) != 0) op = OP_PUSH;
            if ($urandom_range(0, 1) == 0) val = WIDTH'($urandom_range(0, 20));
            else val = WIDTH'($urandom);
            applyStimulus(op, val);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        waitIdle();
        @(negedge clk);
        checkEn = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
